button_gesture_decoder: RTL

- Consumes the debounced level from the button debouncer (its db_level output) and classifies press patterns into single-cycle event pulses: short press, long press and double press.
- Sits between the debouncer and the UI/control FSMs, so that downstream logic never times presses itself.
- Counts in clk cycles at 100 MHz; defaults give a 0.5 s long-press threshold and a 0.25 s double-press window.

---
 rtl/button_pkg.sv | 15 +
 rtl/gesture_timer.sv | 30 +++
 rtl/button_gesture_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and 100 MHz default timing for the button gesture decoder.
package button_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESS1 = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] PRESS2 = 3'd3;
    localparam logic [2:0] HELD   = 3'd4;

    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_GAP_CYCLES    = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/gesture_timer.sv
// Shared gesture counter: clear has priority over enable; at_limit flags cnt == limit-1.
module gesture_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_at_limit = (r_cnt == i_limit - ONE);

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced presses into short/long/double pulses.
// Optional auto-repeat in HELD is enabled by defining GESTURE_REPEAT_EN.
module button_gesture_decoder
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic gesture_active
);

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
`ifdef GESTURE_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES);
`endif

    logic [2:0]       r_state;
    logic             r_prev;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_active;
    logic             w_rise;
    logic             w_clear;
    logic             w_en;
    logic             w_at_limit;
    logic [CNT_W-1:0] w_limit;

    assign w_rise = btn_level & ~r_prev;

    // Counter runs only while the current phase continues; any transition clears it.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_en    = 1'b0;
        w_limit = LONG_LIM;
        case (r_state)
            PRESS1: w_en = btn_level & ~w_at_limit;
            GAP: begin
                w_limit = GAP_LIM;
                w_en    = ~btn_level & ~w_at_limit;
            end
            PRESS2: w_en = btn_level & ~w_at_limit;
`ifdef GESTURE_REPEAT_EN
            HELD: begin
                w_limit = REPEAT_LIM;
                w_en    = btn_level & ~w_at_limit;
            end
`endif
            default: w_en = 1'b0;
        endcase
        w_clear = ~w_en;
    end

    gesture_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_en      (w_en),
        .i_limit   (w_limit),
        .o_at_limit(w_at_limit)
    );

`ifdef GESTURE_REPEAT_EN
    logic r_repeat;
`endif

    // prev_level resets high so a button already held at reset cannot look like a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_prev   <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_active <= 1'b0;
`ifdef GESTURE_REPEAT_EN
            r_repeat <= 1'b0;
`endif
        end else begin
            r_prev   <= btn_level;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
`ifdef GESTURE_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state  <= PRESS1;
                        r_active <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (!btn_level) begin
                        r_state <= GAP;
                    end else if (w_at_limit) begin
                        r_long  <= 1'b1;
                        r_state <= HELD;
                    end
                end
                GAP: begin
                    if (btn_level) begin
                        r_state <= PRESS2;
                    end else if (w_at_limit) begin
                        r_short  <= 1'b1;
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                PRESS2: begin
                    if (!btn_level) begin
                        r_double <= 1'b1;
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end else if (w_at_limit) begin
                        r_double <= 1'b1;
                        r_state  <= HELD;
                    end
                end
                HELD: begin
                    if (!btn_level) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
`ifdef GESTURE_REPEAT_EN
                    else if (w_at_limit) begin
                        r_repeat <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign short_press    = r_short;
    assign long_press     = r_long;
    assign double_press   = r_double;
    assign gesture_active = r_active;
`ifdef GESTURE_REPEAT_EN
    assign repeat_tick    = r_repeat;
`else
    assign repeat_tick    = 1'b0;
`endif

endmodule
